// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int N_DEF = 8;
    localparam int CNT_W = $clog2(2 * N_DEF);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // A zero divisor saturates every quotient bit; the remainder passes the dividend low bits.
    localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_restoring_step
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] pr,
    input  logic         q_msb,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] pr_next,
    output logic         q_bit
);

    // The shifted value needs N+1 bits; after the restore it is always below the divisor.
    logic [N:0] shifted;

    always_comb begin
        shifted = {pr, q_msb};
        q_bit   = (shifted >= {1'b0, divisor});
        pr_next = q_bit ? N'(shifted - {1'b0, divisor}) : shifted[N-1:0];
    end

endmodule

// File: rtl/unsigned_restoring_divider_16by8.sv
// Sequential unsigned 2N/N restoring divider with valid/ready handshakes on both sides.
module unsigned_restoring_divider_16by8
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = (N == N_DEF) ? CNT_W : $clog2(2 * N);

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] q_reg;
    logic [N-1:0]   pr_reg;
    logic [N-1:0]   dvsr_reg;
    logic [N-1:0]   rem_reg;
    logic           dbz_reg;
    logic [N-1:0]   pr_next;
    logic           q_bit;
    logic           accept;

    div_restoring_step #(.N(N)) u_step (
        .pr      (pr_reg),
        .q_msb   (q_reg[2*N-1]),
        .divisor (dvsr_reg),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    assign accept = in_valid && in_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            q_reg    <= '0;
            pr_reg   <= '0;
            dvsr_reg <= '0;
            rem_reg  <= '0;
            dbz_reg  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) begin
                if (divisor == '0) begin
                    q_reg   <= {(2*N){DBZ_Q_FILL}};
                    rem_reg <= dividend[N-1:0];
                    dbz_reg <= 1'b1;
                end else begin
                    q_reg    <= dividend;
                    dvsr_reg <= divisor;
                    pr_reg   <= '0;
                    cnt      <= CW'(2 * N - 1);
                end
            end else if (state == CALC) begin
                // The quotient register doubles as the dividend shifter.
                pr_reg <= pr_next;
                q_reg  <= {q_reg[2*N-2:0], q_bit};
                cnt    <= cnt - 1'b1;
                if (cnt == '0) begin
                    rem_reg <= pr_next;
                    dbz_reg <= 1'b0;
                end
            end
        end
    end

    assign quotient    = q_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dbz_reg;

endmodule
